// File: rtl/alu_sequencer.sv
// alu_sequencer: two-requester round-robin front end for a 32-bit ALU.
// Accepts one operation at a time, drives registered ALU operands, times the
// multi-cycle MOD unit with a down-counter and returns the captured result.
module alu_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MOD_CYCLES = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = (MOD_CYCLES > 1) ? $clog2(MOD_CYCLES) : 1;

  localparam logic [OP_W-1:0] OP_SLT = 3'b100;
  localparam logic [OP_W-1:0] OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              ptr;
  logic              gnt;
  logic [CNT_W-1:0]  cnt;

  logic              sel;
  logic              accept;
  logic              capture;
  logic              finish;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [OP_W-1:0]   sel_op;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, arbitration and combinational request accept
  always_comb begin
    next_state = state;
    req_ready  = '0;
    sel        = ptr;
    accept     = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (reset && (req_valid != 2'b00)) begin
          if (req_valid == 2'b01) begin
            sel = 1'b0;
          end else if (req_valid == 2'b10) begin
            sel = 1'b1;
          end
          accept         = 1'b1;
          req_ready[sel] = 1'b1;
          next_state     = EXEC;
        end
      end
      EXEC: begin
        if ((alu_op != OP_MOD) || (cnt == '0)) begin
          capture    = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (resp_ready[gnt]) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    sel_a  = sel ? req_a1  : req_a0;
    sel_b  = sel ? req_b1  : req_b0;
    sel_op = sel ? req_op1 : req_op0;
  end

  // Datapath, MOD timer, round-robin pointer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= 1'b0;
      gnt        <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      resp_data  <= '0;
      resp_valid <= '0;
      busy       <= 1'b0;
    end else begin
      busy       <= (next_state != IDLE);
      resp_valid <= (next_state == RESP) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
      alu_start  <= accept && (sel_op == OP_MOD);
      if (accept) begin
        alu_a  <= sel_a;
        alu_b  <= sel_b;
        alu_op <= sel_op;
        gnt    <= sel;
        if (sel_op == OP_MOD) begin
          cnt <= CNT_W'(MOD_CYCLES - 1);
        end
      end else if ((state == EXEC) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      // The ALU smears the less-than bit across the word; return it as 0/1
      if (capture) begin
        resp_data <= (alu_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, alu_result[0]} : alu_result;
      end
      if (finish) begin
        ptr <= ~gnt;
      end
    end
  end

endmodule
